// File: rtl/branch_resolver.sv
// Execute-stage branch resolver: decodes the comparator flags into a branch outcome, flags mispredictions,
// redirects fetch and holds a fixed-length flush. Optional stats counters are enabled by `define BRANCH_STATS_EN.
module branch_resolver #(
  parameter int PC_W         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_in,
  output logic            ready_in,
  input  logic [2:0]      br_type,
  input  logic            zero,
  input  logic            positive,
  input  logic            negative,
  input  logic [PC_W-1:0] pc_in,
  input  logic [PC_W-1:0] target_in,
  input  logic            pred_taken,
  output logic            resolved_valid,
  output logic            resolved_taken,
  output logic            mispredict,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic            flush,
  output logic            flag_err,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count
);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;
  logic       accept;
  logic       flags_onehot;
  logic       taken_next;
  logic       mispred_next;

  assign accept = valid_in && ready_in;

  // Conditional branches with inconsistent comparator flags are forced not-taken.
  always_comb begin
    flags_onehot = 1'b0;
    case ({zero, positive, negative})
      3'b100, 3'b010, 3'b001: flags_onehot = 1'b1;
      default:                flags_onehot = 1'b0;
    endcase

    taken_next = 1'b0;
    case (br_type)
      3'd0:    taken_next = zero;
      3'd1:    taken_next = !zero;
      3'd2:    taken_next = positive;
      3'd3:    taken_next = negative;
      3'd4:    taken_next = zero | positive;
      3'd5:    taken_next = zero | negative;
      3'd6:    taken_next = 1'b1;
      default: taken_next = 1'b0;
    endcase
    if (!flags_onehot && (br_type < 3'd6))
      taken_next = 1'b0;

    mispred_next = taken_next ^ pred_taken;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // The counter holds the number of flush cycles still to go after the current one.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept && mispred_next) begin
          state_next = FLUSH;
          cnt_next   = 4'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (cnt == 4'd0)
          state_next = IDLE;
        else
          cnt_next = cnt - 4'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready_in = (state == IDLE);
    flush    = (state == FLUSH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resolved_valid <= 1'b0;
      resolved_taken <= 1'b0;
      mispredict     <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flag_err       <= 1'b0;
    end else begin
      resolved_valid <= accept;
      redirect_valid <= accept && mispred_next;
      flag_err       <= accept && !flags_onehot;
      if (accept) begin
        resolved_taken <= taken_next;
        mispredict     <= mispred_next;
        redirect_pc    <= taken_next ? target_in : pc_in + PC_W'(4);
      end
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      branch_count     <= 32'd0;
      mispredict_count <= 32'd0;
    end else if (accept) begin
      branch_count <= branch_count + 32'd1;
      if (mispred_next)
        mispredict_count <= mispredict_count + 32'd1;
    end
  end
`else
  assign branch_count     = 32'd0;
  assign mispredict_count = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed steps plus random branches against a
// behavioural model built from comparison relations and a remaining-flush-cycles count.
module tb_branch_resolver;

  localparam int PC_W         = 32;
  localparam int FLUSH_CYCLES = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            valid_in;
  logic            ready_in;
  logic [2:0]      br_type;
  logic            zero, positive, negative;
  logic [PC_W-1:0] pc_in, target_in;
  logic            pred_taken;
  logic            resolved_valid, resolved_taken, mispredict;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            flush, flag_err;
  logic [31:0]     branch_count, mispredict_count;

  int tests = 0;
  int fails = 0;

  // Model state: outputs expected after the next edge and flush cycles remaining.
  int          flush_left = 0;
  logic        e_rv = 0, e_rt = 0, e_mp = 0, e_rdv = 0, e_ferr = 0;
  logic [31:0] e_rpc = 0, e_bc = 0, e_mc = 0;

  branch_resolver #(.PC_W(PC_W), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_in(ready_in),
    .br_type(br_type), .zero(zero), .positive(positive), .negative(negative),
    .pc_in(pc_in), .target_in(target_in), .pred_taken(pred_taken),
    .resolved_valid(resolved_valid), .resolved_taken(resolved_taken),
    .mispredict(mispredict), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush(flush), .flag_err(flag_err),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  function automatic logic ref_taken(input logic [2:0] t, input logic z, input logic p, input logic n);
    int nflags;
    int rel;
    nflags = int'(z) + int'(p) + int'(n);
    rel = z ? 0 : (p ? 1 : -1);
    if (t == 3'd6) return 1'b1;
    if (t == 3'd7) return 1'b0;
    if (nflags != 1) return 1'b0;
    case (t)
      3'd0:    return rel == 0;
      3'd1:    return rel != 0;
      3'd2:    return rel > 0;
      3'd3:    return rel < 0;
      3'd4:    return rel >= 0;
      default: return rel <= 0;
    endcase
  endfunction

  task automatic modelEdge();
    logic acc, tk;
    if (!rst_n) begin
      flush_left = 0;
      {e_rv, e_rt, e_mp, e_rdv, e_ferr} = '0;
      e_rpc = 0; e_bc = 0; e_mc = 0;
      return;
    end
    acc = valid_in && (flush_left == 0);
    e_rv = acc; e_rdv = 1'b0; e_ferr = 1'b0;
    if (flush_left > 0) flush_left--;
    if (acc) begin
      tk = ref_taken(br_type, zero, positive, negative);
      e_rt = tk;
      e_mp = (tk != pred_taken);
      e_rdv = e_mp;
      e_ferr = (int'(zero) + int'(positive) + int'(negative)) != 1;
      e_rpc = tk ? target_in : 32'(pc_in + 32'd4);
`ifdef BRANCH_STATS_EN
      e_bc++;
      if (e_mp) e_mc++;
`endif
      if (e_mp) flush_left = FLUSH_CYCLES;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    checkOutput("ready_in", 32'(ready_in), 32'(flush_left == 0));
    checkOutput("flush", 32'(flush), 32'(flush_left > 0));
    checkOutput("resolved_valid", 32'(resolved_valid), 32'(e_rv));
    checkOutput("resolved_taken", 32'(resolved_taken), 32'(e_rt));
    checkOutput("mispredict", 32'(mispredict), 32'(e_mp));
    checkOutput("redirect_valid", 32'(redirect_valid), 32'(e_rdv));
    checkOutput("redirect_pc", redirect_pc, e_rpc);
    checkOutput("flag_err", 32'(flag_err), 32'(e_ferr));
    checkOutput("branch_count", branch_count, e_bc);
    checkOutput("mispredict_count", mispredict_count, e_mc);
  endtask

  // Drive one cycle of inputs, advance past the edge and compare at the falling edge.
  task automatic applyStimulus(input logic v, input logic [2:0] t, input logic [2:0] zpn,
                               input logic [31:0] pc, input logic [31:0] tgt, input logic pt);
    valid_in = v; br_type = t;
    {zero, positive, negative} = zpn;
    pc_in = pc; target_in = tgt; pred_taken = pt;
    modelEdge();
    @(posedge clk);
    @(negedge clk);
    checkAll();
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1, 3'd6, 3'b100, 32'h10, 32'h20, 0);
    rst_n = 1'b1;

    applyStimulus(1, 3'd0, 3'b100, 32'h100, 32'h200, 1);
    applyStimulus(1, 3'd1, 3'b010, 32'h104, 32'h300, 1);
    applyStimulus(1, 3'd3, 3'b010, 32'h40, 32'h80, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 3'd6, 3'b001, 32'h50, 32'h500, 0);
    applyStimulus(1, 3'd0, 3'b001, 32'hFFFF_FFFC, 32'h1000, 1);
    for (int i = 0; i < 2; i++) applyStimulus(0, 3'd0, 3'b100, 32'h0, 32'h0, 0);
    applyStimulus(1, 3'd0, 3'b110, 32'h60, 32'h600, 0);
    applyStimulus(1, 3'd7, 3'b100, 32'h70, 32'h700, 1);
    for (int i = 0; i < 2; i++) applyStimulus(0, 3'd0, 3'b100, 32'h0, 32'h0, 0);

    applyStimulus(1, 3'd2, 3'b001, 32'h80, 32'h800, 1);
    rst_n = 1'b0;
    applyStimulus(1, 3'd2, 3'b010, 32'h84, 32'h840, 1);
    rst_n = 1'b1;

    applyStimulus(1, 3'd4, 3'b100, 32'h90, 32'h900, 1);
    applyStimulus(1, 3'd5, 3'b010, 32'h94, 32'h940, 1);
    for (int i = 0; i < 2; i++) applyStimulus(0, 3'd0, 3'b100, 32'h0, 32'h0, 0);
    applyStimulus(1, 3'd6, 3'b000, 32'h98, 32'h980, 1);
    applyStimulus(1, 3'd2, 3'b001, 32'h9C, 32'h9C0, 0);
    applyStimulus(1, 3'd5, 3'b001, 32'hA0, 32'hA00, 0);

    for (int i = 0; i < 400; i++) begin
      logic [2:0] zpn;
      logic [31:0] pc;
      rst_n = ($urandom_range(0, 99) != 0);
      case ($urandom_range(0, 3))
        0:       zpn = 3'($urandom);
        1:       zpn = 3'b100;
        2:       zpn = 3'b010;
        default: zpn = 3'b001;
      endcase
      pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : {$urandom} & 32'hFFFF_FFFC;
      applyStimulus(1'($urandom_range(0, 3) != 0), 3'($urandom), zpn, pc, $urandom, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

- Execute-stage block directly downstream of the signed comparator.
- Each cycle it can accept one branch: the comparator's zero/positive/negative flags, the branch type, the branch PC/target and the fetch-stage prediction.
- It registers the actual branch outcome and detects mispredictions.
- On a misprediction it drives a one-cycle PC redirect and holds a pipeline flush for a fixed number of cycles, backpressuring new branches while flushing.

## Interface

Parameters:
- PC_W, 32, PC and target width.
- FLUSH_CYCLES, 2, cycles `flush` stays high after a misprediction; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- valid_in  input  1  branch present this cycle.
- ready_in  output  1  block can accept a branch.
- br_type  input  3  branch type encoding (see Operation).
- zero  input  1  comparator flag: A == B.
- positive  input  1  comparator flag: signed A > B.
- negative  input  1  comparator flag: signed A < B.
- pc_in  input  PC_W  PC of the branch.
- target_in  input  PC_W  taken target.
- pred_taken  input  1  fetch-stage prediction.
- resolved_valid  output  1  one-cycle pulse per accepted branch.
- resolved_taken  output  1  actual outcome, valid with resolved_valid.
- mispredict  output  1  outcome differs from pred_taken, valid with resolved_valid.
- redirect_valid  output  1  one-cycle pulse; fetch must load redirect_pc.
- redirect_pc  output  PC_W  correct next PC.
- flush  output  1  squash younger instructions in IF/ID.
- flag_err  output  1  one-cycle pulse: flags were not one-hot on accept.
- branch_count  output  32  accepted branches (stats).
- mispredict_count  output  32  mispredictions (stats).

## Operation

- Accept occurs when valid_in && ready_in.
- ready_in = (state == IDLE); it is combinational from state only.
- br_type decode to taken:
  - 0 BEQ: zero
  - 1 BNE: !zero
  - 2 BGT: positive
  - 3 BLT: negative
  - 4 BGE: zero|positive
  - 5 BLE: zero|negative
  - 6 JMP: 1
  - 7 reserved: 0
- Flags not exactly one-hot on accept:
  - Conditional types 0–5 resolve not-taken; types 6 and 7 are unaffected.
  - flag_err pulses.
- redirect_pc:
  - target_in if taken.
  - Otherwise pc_in + 4, modulo 2^PC_W (wraps, no carry out).
- State machine:
  - IDLE: on accept with mispredict, go to FLUSH and load flush counter with FLUSH_CYCLES-1. On accept without mispredict, or no accept, stay in IDLE.
  - FLUSH: valid_in is ignored (ready_in=0). Counter decrements each cycle; at 0, go to IDLE.
- flush = (state == FLUSH).
- redirect_valid = resolved_valid && mispredict.
- On a correct prediction there is no redirect and no flush, but resolved_valid still pulses.
- Reset values (all outputs and state): every output 0 except ready_in=1; state IDLE; counters 0.
- Reset asserted mid-FLUSH: the next edge forces IDLE, flush=0, and discards pending redirect/outputs.

## Timing

- Latency 1: accept at edge N → resolved_*, redirect_*, flag_err visible after edge N, for exactly one cycle.
- Output-side pulses (resolved_valid, redirect_valid, flag_err) last one cycle and then return to 0 unless another accept occurs.
- Data outputs (resolved_taken, mispredict, redirect_pc) hold their last values between pulses.
- Correct predictions sustain one accept per cycle back-to-back.
- After a mispredict accepted at edge N:
  - flush is high for cycles N+1 .. N+FLUSH_CYCLES.
  - ready_in is low for the same cycles.
  - The next accept is possible at edge N+FLUSH_CYCLES+1.
- valid_in held high during FLUSH is not accepted; the upstream stage keeps it pending.

## Configuration

- BRANCH_STATS_EN defined:
  - branch_count increments on every accept.
  - mispredict_count increments on every mispredicting accept, in the same edge.
  - Both are 32-bit and wrap at 2^32; both reset to 0.
- BRANCH_STATS_EN undefined: both outputs are tied to constant 0 and no counter flops exist.

## Test plan

- Reset: hold rst_n=0 for 3 cycles with valid_in=1 → all outputs 0, ready_in=1, no accept.
- BEQ correct prediction: br_type=0, zero=1, pred_taken=1, pc_in=0x100, target_in=0x200 → next cycle resolved_valid=1, resolved_taken=1, mispredict=0, no redirect, no flush; a back-to-back branch is accepted the following cycle.
- BLT mispredict, FLUSH_CYCLES=2: br_type=3, negative=0, positive=1, pred_taken=1, pc_in=0x40 → redirect_valid=1 with redirect_pc=0x44 for one cycle; flush=1 and ready_in=0 for 2 cycles; valid_in held during those cycles is ignored; the branch is accepted on cycle 3.
- Boundaries:
  - pc_in=0xFFFFFFFC, not-taken mispredict → redirect_pc=0x00000000.
  - Flags zero=1, positive=1, br_type=0 → not taken, flag_err pulse.
  - br_type=7 → not taken.
- Reset mid-flush: mispredict, then rst_n=0 on the first flush cycle → after that edge flush=0, ready_in=1, counters 0.
- Stats (BRANCH_STATS_EN): 5 branches including 2 mispredicts → branch_count=5, mispredict_count=2. Without the macro, both read 0 throughout.
